// File: rtl/alu_muldiv_pkg.sv
// Operation codes (RV32M funct3) and FSM encodings for the iterative mul/div unit.
package alu_muldiv_pkg;
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic op_signed0(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_signed1(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction
endpackage

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: one shared adder, one result bit per cycle,
// magnitudes in the datapath with sign correction applied in FIX.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_0,
  input  logic [XLEN-1:0] in_1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [2:0]      op_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]   hi;   // product high half / partial remainder
  logic [XLEN-1:0] lo;   // multiplier shifting out / dividend out, quotient in
  logic [XLEN-1:0] b;    // multiplicand / divisor magnitude
  logic            neg_q, neg_r;

  // operand decode
  logic            s0, s1, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag0, mag1, special_res;

  always_comb begin
    s0       = op_signed0(op) & in_0[XLEN-1];
    s1       = op_signed1(op) & in_1[XLEN-1];
    mag0     = s0 ? (~in_0 + 1'b1) : in_0;
    mag1     = s1 ? (~in_1 + 1'b1) : in_1;
    div_zero = op[2] && (in_1 == '0);
    div_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) && (in_0 == MIN_NEG) && (&in_1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = op[1] ? in_0 : '1;
    else          special_res = op[1] ? '0 : in_0;
  end

  // shared add/subtract step: mul adds b when the multiplier lsb is set,
  // div trial-subtracts b from the shifted partial remainder
  logic            is_div;
  logic [XLEN:0]   add_a, add_b, sum;

  always_comb begin
    is_div = op_q[2];
    add_a  = is_div ? {hi[XLEN-1:0], lo[XLEN-1]} : hi;
    if (is_div)     add_b = ~{1'b0, b};
    else if (lo[0]) add_b = {1'b0, b};
    else            add_b = '0;
    sum = add_a + add_b + {{XLEN{1'b0}}, is_div};
  end

  // sign correction; MULH* negates the full double-width product
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod   = {hi[XLEN-1:0], lo};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quo    = neg_q ? (~lo + 1'b1) : lo;
    rem    = neg_r ? (~hi[XLEN-1:0] + 1'b1) : hi[XLEN-1:0];
    case (op_q)
      MDU_MUL:                       fix_res = prod_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:             fix_res = quo;
      default:                       fix_res = rem;
    endcase
  end

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= MDU_MUL;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      b         <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q  <= op;
          cnt   <= '0;
          neg_q <= s0 ^ s1;
          neg_r <= s0;
          hi    <= '0;
          b     <= op[2] ? mag1 : mag0;
          lo    <= op[2] ? mag0 : mag1;
          if (special) begin
            out       <= special_res;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (!is_div) begin
            hi <= {1'b0, sum[XLEN:1]};
            lo <= {sum[0], lo[XLEN-1:1]};
          end else if (!sum[XLEN]) begin
            hi <= sum;
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= add_a;
            lo <= {lo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          out       <= fix_res;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
